// File: rtl/clock_seg_display.sv
// -----------------------------------------------------------------------------
// clock_seg_display
//
// Display back-end for the digital clock. Once per scan frame the packed time
// word {hours, minutes, seconds} is captured, converted to six BCD digits by a
// sequential double-dabble engine, and loaded into a display buffer. That
// buffer is then multiplexed onto a common-anode 7-segment display one digit
// at a time. Because the buffer only changes atomically after a complete
// conversion, a frame never shows a torn time value.
//
// Parameters
//   SCAN_CNT  digit dwell is SCAN_CNT+1 clk cycles (must be >= 30 so that a
//             conversion always completes inside one frame)
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   data_in   [23:16] hours, [15:8] minutes, [7:0] seconds, binary per byte
//   seg_sel   digit select, active-low one-hot, bit 5 = hour tens,
//             bit 0 = second ones (registered)
//   seg_data  segments, active-low {dp,g,f,e,d,c,b,a} (registered)
// -----------------------------------------------------------------------------
module clock_seg_display #(
    parameter int unsigned SCAN_CNT = 49_999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] data_in,
    output logic [5:0]  seg_sel,
    output logic [7:0]  seg_data
);

    // +2 keeps the width at least one bit for any SCAN_CNT
    localparam int unsigned CNT_W = $clog2(SCAN_CNT + 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the
    // next binary bit in at the bottom.
    function automatic logic [11:0] dd_step(input logic [11:0] acc,
                                            input logic        bit_in);
        logic [11:0] adj;
        adj = 12'h000;
        for (int i = 0; i < 3; i++) begin
            adj[i*4 +: 4] = (acc[i*4 +: 4] >= 4'd5) ? (acc[i*4 +: 4] + 4'd3)
                                                    : acc[i*4 +: 4];
        end
        return {adj[10:0], bit_in};
    endfunction

    // Active-low segment pattern for one digit. Invalid fields show a dash;
    // dp_on lights the decimal point used as a field separator.
    function automatic logic [7:0] seg_decode(input logic [3:0] digit,
                                              input logic       invalid,
                                              input logic       dp_on);
        logic [7:0] pat;
        if (invalid) begin
            pat = 8'hBF;
        end else begin
            case (digit)
                4'd0:    pat = 8'hC0;
                4'd1:    pat = 8'hF9;
                4'd2:    pat = 8'hA4;
                4'd3:    pat = 8'hB0;
                4'd4:    pat = 8'h99;
                4'd5:    pat = 8'h92;
                4'd6:    pat = 8'h82;
                4'd7:    pat = 8'hF8;
                4'd8:    pat = 8'h80;
                4'd9:    pat = 8'h90;
                default: pat = 8'hFF;
            endcase
        end
        return dp_on ? (pat & 8'h7F) : pat;
    endfunction

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] scan_cnt_r;
    logic [2:0]       dig_r;
    logic             tick_s;
    logic             frame_start_s;

    logic [23:0]      cap_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [4:0]       bit_cnt_r;     // 0..23, field = bit_cnt_r[4:3]
    logic [11:0]      bcd_r;         // {hundreds, tens, ones} accumulator
    logic [11:0]      dd_next_s;
    logic             cap_bit_s;

    logic [23:0]      res_r;         // {h_t, h_o, m_t, m_o, s_t, s_o}
    logic [2:0]       inv_r;         // {hours, minutes, seconds} invalid
    logic [23:0]      disp_dig_r;
    logic [2:0]       disp_inv_r;

    logic [3:0]       nib_s;
    logic             nib_inv_s;
    logic             dp_s;

    assign tick_s        = (scan_cnt_r == CNT_W'(SCAN_CNT));
    assign frame_start_s = tick_s && (dig_r == 3'd5);

    // -------------------------------------------------------------------------
    // Scan timing
    // -------------------------------------------------------------------------

    // Dwell counter and digit index; the digit advances on every tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r <= '0;
            dig_r      <= 3'd0;
        end else if (tick_s) begin
            scan_cnt_r <= '0;
            dig_r      <= (dig_r == 3'd5) ? 3'd0 : (dig_r + 3'd1);
        end else begin
            scan_cnt_r <= scan_cnt_r + CNT_W'(1);
        end
    end

    // Input capture: data_in is only sampled at frame start, so changes at
    // any other time cannot tear the frame being shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_r <= 24'h000000;
        end else if (frame_start_s) begin
            cap_r <= data_in;
        end else begin
            cap_r <= cap_r;
        end
    end

    // -------------------------------------------------------------------------
    // Converter FSM
    // -------------------------------------------------------------------------

    // Converter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Converter next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start_s) begin
                    state_nxt_s = ST_CONV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (bit_cnt_r == 5'd23) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CONV;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Bits are consumed MSB first across the whole 24-bit word, which walks
    // hours, then minutes, then seconds without a separate field pointer.
    always_comb begin
        cap_bit_s = cap_r[5'd23 - bit_cnt_r];
        dd_next_s = dd_step(bcd_r, cap_bit_s);
    end

    // Double-dabble datapath: one shift per CONV cycle; after the 8th shift of
    // a field its two BCD digits and its >99 flag are parked in res_r/inv_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= 5'd0;
            bcd_r     <= 12'h000;
            res_r     <= 24'h000000;
            inv_r     <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (frame_start_s) begin
                        bit_cnt_r <= 5'd0;
                        bcd_r     <= 12'h000;
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                        bcd_r     <= bcd_r;
                    end
                end
                ST_CONV: begin
                    bit_cnt_r <= bit_cnt_r + 5'd1;
                    if (bit_cnt_r[2:0] == 3'd7) begin
                        bcd_r <= 12'h000;
                        case (bit_cnt_r[4:3])
                            2'd0: begin
                                res_r[23:16] <= dd_next_s[7:0];
                                inv_r[2]     <= (dd_next_s[11:8] != 4'd0);
                            end
                            2'd1: begin
                                res_r[15:8]  <= dd_next_s[7:0];
                                inv_r[1]     <= (dd_next_s[11:8] != 4'd0);
                            end
                            2'd2: begin
                                res_r[7:0]   <= dd_next_s[7:0];
                                inv_r[0]     <= (dd_next_s[11:8] != 4'd0);
                            end
                            default: begin
                                res_r <= res_r;
                                inv_r <= inv_r;
                            end
                        endcase
                    end else begin
                        bcd_r <= dd_next_s;
                    end
                end
                default: begin
                    bit_cnt_r <= bit_cnt_r;
                    bcd_r     <= bcd_r;
                end
            endcase
        end
    end

    // Display buffer: all six digits and flags load together in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_dig_r <= 24'h000000;
            disp_inv_r <= 3'b000;
        end else if (state_r == ST_DONE) begin
            disp_dig_r <= res_r;
            disp_inv_r <= inv_r;
        end else begin
            disp_dig_r <= disp_dig_r;
            disp_inv_r <= disp_inv_r;
        end
    end

    // -------------------------------------------------------------------------
    // Digit multiplexing and outputs
    // -------------------------------------------------------------------------

    // Pick the BCD nibble, its field's invalid flag and the separator dot for
    // the current digit index (dig 0 = second ones ... dig 5 = hour tens).
    always_comb begin
        nib_s     = 4'd0;
        nib_inv_s = 1'b0;
        dp_s      = 1'b0;
        case (dig_r)
            3'd0: begin nib_s = disp_dig_r[3:0];   nib_inv_s = disp_inv_r[0]; end
            3'd1: begin nib_s = disp_dig_r[7:4];   nib_inv_s = disp_inv_r[0]; end
            3'd2: begin nib_s = disp_dig_r[11:8];  nib_inv_s = disp_inv_r[1]; dp_s = 1'b1; end
            3'd3: begin nib_s = disp_dig_r[15:12]; nib_inv_s = disp_inv_r[1]; end
            3'd4: begin nib_s = disp_dig_r[19:16]; nib_inv_s = disp_inv_r[2]; dp_s = 1'b1; end
            3'd5: begin nib_s = disp_dig_r[23:20]; nib_inv_s = disp_inv_r[2]; end
            default: begin
                nib_s     = 4'd0;
                nib_inv_s = 1'b0;
                dp_s      = 1'b0;
            end
        endcase
    end

    // Registered outputs; select and data come from the same dig_r so they
    // always change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_sel  <= 6'h3F;
            seg_data <= 8'hFF;
        end else begin
            seg_sel  <= ~(6'd1 << dig_r);
            seg_data <= seg_decode(nib_s, nib_inv_s, dp_s);
        end
    end

endmodule

// File: tb/tb_clock_seg_display.sv
module tb_clock_seg_display;

    localparam int SCAN = 31;
    localparam int DW   = SCAN + 1;   // dwell per digit
    localparam int F    = 6 * DW;     // frame period

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic [23:0] data_in = 24'h000000;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_data;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] early;   // value at the start of the dwell
        logic [7:0] late;    // value at the end of the dwell
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] lut [0:9];

    clock_seg_display #(.SCAN_CNT(SCAN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .seg_sel  (seg_sel),
        .seg_data (seg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // Reference: what digit d (0 = second ones .. 5 = hour tens) of time t looks like.
    function automatic logic [7:0] exp_digit(input logic [23:0] t, input int d);
        int         val;
        logic [7:0] pat;
        val = int'((t >> (8 * (d / 2))) & 24'h0000FF);
        if (val > 99)
            pat = 8'hBF;
        else if (d % 2 == 0)
            pat = lut[val % 10];
        else
            pat = lut[val / 10];
        if (d == 2 || d == 4)
            pat[7] = 1'b0;
        return pat;
    endfunction

    // Expected presentations of one frame: digit 0 starts with the previous
    // frame's time and ends with the new one, digits 1..5 show the new time.
    task automatic push_frame(input logic [23:0] prev, input logic [23:0] cur);
        exp_t e;
        for (int d = 0; d < 6; d++) begin
            e.sel   = 6'h3F ^ (6'h01 << d);
            e.early = (d == 0) ? exp_digit(prev, 0) : exp_digit(cur, d);
            e.late  = exp_digit(cur, d);
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [23:0] pick_value(input int k, input bit force_ref);
        logic [23:0] v;
        if (force_ref)
            v = 24'h173B3B;
        else begin
            case (k)
                0: v = 24'h173B3B;
                1: v = 24'h640A00;
                2: v = 24'h000000;
                3: v = 24'h01020C;
                4: v = 24'h6364FF;
                default: begin
                    if ($urandom_range(0, 1) == 0)
                        v = {8'($urandom_range(0, 23)), 8'($urandom_range(0, 59)), 8'($urandom_range(0, 59))};
                    else
                        v = 24'($urandom);
                end
            endcase
        end
        return v;
    endfunction

    // Release reset and run n frames, each ending with a capture edge.
    // With abort set, reset is re-asserted 10 cycles after the last capture.
    task automatic run_frames(input int n, input bit abort);
        logic [23:0] prev;
        logic [23:0] cur;
        logic [23:0] nv;
        int          chg_at;
        @(posedge clk);
        #2;
        exp_q.delete();
        prev = 24'h000000;
        push_frame(24'h000000, 24'h000000);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            nv     = pick_value(k, abort && (k == n - 1));
            chg_at = (k < 5) ? (2 * DW + 5) : $urandom_range(1, F - 1);
            for (int i = 1; i <= F; i++) begin
                @(posedge clk);
                #1;
                if (i == chg_at)
                    data_in = nv;
                else if (i < chg_at && $urandom_range(0, 31) == 0)
                    data_in = 24'($urandom);
            end
            cur = data_in;        // value held across the capture edge
            push_frame(prev, cur);
            prev = cur;
        end
        if (abort) begin
            repeat (10) @(posedge clk);
            #2;
            rst_n  = 1'b0;
            mon_en = 1'b0;
            exp_q.delete();
            #1;
            chk("abort_reset_sel", 32'(seg_sel), 32'h3F);
            chk("abort_reset_data", 32'(seg_data), 32'hFF);
        end
    endtask

    // Monitor: each change of seg_sel is a new digit presentation, checked
    // against the scoreboard; dwell length and end-of-dwell value are checked too.
    int         dwell = 0;
    bit         started = 1'b0;
    logic [5:0] last_sel = 6'h3F;
    exp_t       cur_e;

    always @(negedge clk) begin
        if (!mon_en) begin
            dwell    = 0;
            started  = 1'b0;
            last_sel = 6'h3F;
        end else begin
            dwell = dwell + 1;
            if (seg_sel !== last_sel) begin
                if (started)
                    chk("dwell_len", 32'(dwell), 32'(DW));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got sel %h data %h, expected no presentation", seg_sel, seg_data);
                end else begin
                    cur_e = exp_q.pop_front();
                    chk("digit_sel", 32'(seg_sel), 32'(cur_e.sel));
                    chk("digit_data_start", 32'(seg_data), 32'(cur_e.early));
                end
                started  = 1'b1;
                last_sel = seg_sel;
                dwell    = 0;
            end else if (started && dwell == DW - 1) begin
                chk("digit_data_end", 32'(seg_data), 32'(cur_e.late));
            end else if (dwell > DW + 1) begin
                checks++;
                errors++;
                $display("FAIL scan_timeout: got sel %h held %0d cycles, expected change within %0d", seg_sel, dwell, DW);
                dwell = 0;
            end
        end
    end

    initial begin
        lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_sel", 32'(seg_sel), 32'h3F);
        chk("reset_data", 32'(seg_data), 32'hFF);
        repeat (3) @(posedge clk);

        // directed values, tear-free capture, random times, then abort mid-conversion
        run_frames(10, 1'b1);
        repeat (3) @(posedge clk);

        // after the aborted conversion the display must start again at 00.00.00
        run_frames(3, 1'b0);

        // asynchronous reset mid-scan
        repeat (37) @(posedge clk);
        #3;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("midscan_reset_sel", 32'(seg_sel), 32'h3F);
        chk("midscan_reset_data", 32'(seg_data), 32'hFF);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
